// File: rtl/alu_pkg.sv
// Shared widths, mode/op encodings and issuer state type for the Alu command path.
package alu_pkg;

  localparam int unsigned OPND_W = 16;
  localparam int unsigned RES_W  = 32;

  localparam logic MODE_BOOL = 1'b0;
  localparam logic MODE_INT  = 1'b1;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_NOT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } issuer_state_t;

endpackage

// File: rtl/alu_cmd_issuer.sv
// Accepts one ALU command, holds it on the Alu inputs for a settle window,
// then returns the sampled result/error and keeps op/error statistics.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPND_W-1:0] cmd_a,
  input  logic [OPND_W-1:0] cmd_b,
  input  logic              cmd_mode,
  input  logic [1:0]        cmd_op,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  output logic              alu_mode,
  output logic [1:0]        alu_op,
  input  logic [RES_W-1:0]  alu_res,
  input  logic              alu_err,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_res,
  output logic              rsp_err,
  output logic [15:0]       ops_count,
  output logic [7:0]        err_count
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  issuer_state_t state, state_nx;
  logic [3:0]    settle_cnt;
  logic          armed;
  logic          accept;
  logic          capture;
  logic          rsp_take;

  // armed keeps cmd_ready low until the first edge after reset release
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    capture   = 1'b0;
    rsp_take  = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = armed;
        if (cmd_valid && armed) begin
          accept   = 1'b1;
          state_nx = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (settle_cnt == '0) begin
          capture  = 1'b1;
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_take = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_mode   <= 1'b0;
      alu_op     <= '0;
      settle_cnt <= '0;
      rsp_res    <= '0;
      rsp_err    <= 1'b0;
      ops_count  <= '0;
      err_count  <= '0;
    end else begin
      if (accept) begin
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
        alu_mode   <= cmd_mode;
        alu_op     <= cmd_op;
        settle_cnt <= SETTLE_LOAD;
      end else if (state == ST_DRIVE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      // boolean ops never report an error, whatever the Alu says
      if (capture) begin
        rsp_res <= alu_res;
        rsp_err <= alu_err & (alu_mode == MODE_INT);
      end
      if (rsp_take) begin
        ops_count <= ops_count + 16'd1;
        if (rsp_err && err_count != '1)
          err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: ALU stand-in, reference model and per-scenario tasks.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int unsigned S_MAIN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        force_err = 1'b0;
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned ops_exp = 0;
  int unsigned err_exp = 0;

  always #5 clk = ~clk;

  // main instance, default settle window
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [15:0] cmd_a = '0, cmd_b = '0;
  logic        cmd_mode = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [15:0] alu_a, alu_b;
  logic        alu_mode;
  logic [1:0]  alu_op;
  logic [31:0] alu_res;
  logic        alu_err;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_res;
  logic        rsp_err;
  logic [15:0] ops_count;
  logic [7:0]  err_count;

  // second instance with the shortest window, used for the saturation run
  logic        s_cmd_valid = 1'b0, s_cmd_ready;
  logic [15:0] s_cmd_a = '0, s_cmd_b = '0;
  logic        s_cmd_mode = 1'b0;
  logic [1:0]  s_cmd_op = '0;
  logic [15:0] s_alu_a, s_alu_b;
  logic        s_alu_mode;
  logic [1:0]  s_alu_op;
  logic        s_rsp_valid, s_rsp_ready = 1'b0;
  logic [31:0] s_rsp_res;
  logic        s_rsp_err;
  logic [15:0] s_ops_count;
  logic [7:0]  s_err_count;

  // Alu behaviour: {err, res}; integer subtract reports an error on borrow
  function automatic logic [32:0] alu_ref(input logic m, input logic [1:0] op,
                                          input logic [15:0] a, input logic [15:0] b,
                                          input logic ferr);
    logic [31:0] r;
    logic        e;
    e = ferr;
    if (m == MODE_BOOL) begin
      case (op)
        OP_AND:  r = {16'h0, a & b};
        OP_OR:   r = {16'h0, a | b};
        OP_XOR:  r = {16'h0, a ^ b};
        default: r = {16'h0, ~a};
      endcase
    end else begin
      case (op)
        2'd0:    r = 32'(a) + 32'(b);
        2'd1: begin r = 32'(a) - 32'(b); e = e | (a < b); end
        2'd2:    r = 32'(a) * 32'(b);
        default: r = {a, b};
      endcase
    end
    return {e, r};
  endfunction

  assign {alu_err, alu_res} = alu_ref(alu_mode, alu_op, alu_a, alu_b, force_err);

  alu_cmd_issuer #(.SETTLE_CYCLES(S_MAIN)) dut (
    .Clock(clk), .Reset_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_mode(cmd_mode), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_op(alu_op),
    .alu_res(alu_res), .alu_err(alu_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_err(rsp_err),
    .ops_count(ops_count), .err_count(err_count)
  );

  alu_cmd_issuer #(.SETTLE_CYCLES(1)) dut_s (
    .Clock(clk), .Reset_n(rst_n),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_a(s_cmd_a), .cmd_b(s_cmd_b), .cmd_mode(s_cmd_mode), .cmd_op(s_cmd_op),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_mode(s_alu_mode), .alu_op(s_alu_op),
    .alu_res({s_alu_a, s_alu_b}), .alu_err(1'b1),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_res(s_rsp_res), .rsp_err(s_rsp_err),
    .ops_count(s_ops_count), .err_count(s_err_count)
  );

  // One command through the main instance; optionally stalls the response and
  // presents a follow-on command (nv/na) while stalled.
  task automatic run_op(input logic m, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input int unsigned stall,
                        input logic nv, input logic [15:0] na,
                        output int unsigned waited);
    logic [32:0] exp;
    logic [31:0] er;
    logic        ee;
    int unsigned lat;
    exp = alu_ref(m, op, a, b, force_err);
    er  = exp[31:0];
    ee  = exp[32] & m;
    waited = 0;
    cmd_mode = m; cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1; rsp_ready = 1'b0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
      fails++;
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    tests++;
    if ({alu_a, alu_b, alu_mode, alu_op, cmd_ready} !== {a, b, m, op, 1'b0}) begin
      $display("FAIL alu_drive: got a=%h b=%h m=%b op=%0d rdy=%b required a=%h b=%h m=%b op=%0d rdy=0",
               alu_a, alu_b, alu_mode, alu_op, cmd_ready, a, b, m, op);
      fails++;
    end
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      rsp_ready = 1'($urandom_range(1));
      @(negedge clk);
      lat++;
    end
    rsp_ready = 1'b0;
    tests++;
    if (lat != S_MAIN) begin
      $display("FAIL rsp_latency: got %0d cycles required %0d", lat, S_MAIN);
      fails++;
    end
    tests++;
    if ({rsp_res, rsp_err} !== {er, ee}) begin
      $display("FAIL rsp_data: got res=%h err=%b required res=%h err=%b", rsp_res, rsp_err, er, ee);
      fails++;
    end
    cmd_a = na;
    cmd_valid = nv;
    for (int unsigned s = 0; s < stall; s++) begin
      @(negedge clk);
      tests++;
      if ({rsp_valid, rsp_res, rsp_err, cmd_ready, alu_a} !== {1'b1, er, ee, 1'b0, a}) begin
        $display("FAIL backpressure_hold: got v=%b res=%h err=%b rdy=%b alu_a=%h required v=1 res=%h err=%b rdy=0 alu_a=%h",
                 rsp_valid, rsp_res, rsp_err, cmd_ready, alu_a, er, ee, a);
        fails++;
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    ops_exp = (ops_exp + 1) % 65536;
    if (ee && err_exp < 255) err_exp++;
    tests++;
    if ({rsp_valid, cmd_ready, ops_count, err_count} !== {1'b0, 1'b1, 16'(ops_exp), 8'(err_exp)}) begin
      $display("FAIL rsp_done: got v=%b rdy=%b ops=%0d errs=%0d required v=0 rdy=1 ops=%0d errs=%0d",
               rsp_valid, cmd_ready, ops_count, err_count, ops_exp, err_exp);
      fails++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({cmd_ready, rsp_valid, alu_a, alu_b, alu_mode, alu_op, rsp_res, rsp_err, ops_count, err_count} !== '0) begin
      $display("FAIL reset_outputs: got rdy=%b v=%b a=%h b=%h res=%h ops=%0d errs=%0d required all 0",
               cmd_ready, rsp_valid, alu_a, alu_b, rsp_res, ops_count, err_count);
      fails++;
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (cmd_ready !== 1'b0) begin
      $display("FAIL ready_before_edge: got %b required 0", cmd_ready);
      fails++;
    end
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL ready_after_edge: got %b required 1", cmd_ready);
      fails++;
    end
  endtask

  task automatic test_and;
    int unsigned w;
    run_op(MODE_BOOL, OP_AND, 16'h00F0, 16'h0FF0, 0, 1'b0, 16'h0, w);
  endtask

  task automatic test_not;
    int unsigned w;
    run_op(MODE_BOOL, OP_NOT, 16'h00FF, 16'h1234, 0, 1'b0, 16'h0, w);
  endtask

  task automatic test_backpressure;
    int unsigned w;
    run_op(MODE_BOOL, OP_XOR, 16'hA5A5, 16'h0F0F, 5, 1'b1, 16'h3C3C, w);
    run_op(MODE_BOOL, OP_XOR, 16'h3C3C, 16'h0F0F, 0, 1'b0, 16'h0, w);
    tests++;
    if (w != 0) begin
      $display("FAIL back_to_back_accept: waited %0d cycles required 0", w);
      fails++;
    end
  endtask

  task automatic test_err_mask;
    int unsigned w;
    force_err = 1'b1;
    run_op(MODE_BOOL, OP_OR, 16'h1111, 16'h2222, 0, 1'b0, 16'h0, w);
    run_op(MODE_INT, 2'd0, 16'h1111, 16'h2222, 1, 1'b0, 16'h0, w);
    force_err = 1'b0;
  endtask

  task automatic test_random;
    int unsigned w;
    for (int unsigned i = 0; i < 16; i++) begin
      force_err = 1'($urandom_range(3) == 0);
      run_op(1'($urandom_range(1)), 2'($urandom_range(3)), 16'($urandom), 16'($urandom),
             $urandom_range(3), 1'b0, 16'h0, w);
    end
    force_err = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    cmd_mode = MODE_INT; cmd_op = 2'd3; cmd_a = 16'h1234; cmd_b = 16'h0005; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({cmd_ready, rsp_valid, alu_a, alu_b, alu_mode, alu_op, rsp_res, rsp_err, ops_count, err_count} !== '0) begin
      $display("FAIL reset_mid_drive: got rdy=%b v=%b a=%h res=%h ops=%0d errs=%0d required all 0",
               cmd_ready, rsp_valid, alu_a, rsp_res, ops_count, err_count);
      fails++;
    end
    ops_exp = 0;
    err_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (cmd_ready !== 1'b0) begin
      $display("FAIL ready_at_release: got %b required 0", cmd_ready);
      fails++;
    end
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL ready_after_release: got %b required 1", cmd_ready);
      fails++;
    end
    repeat (4) begin
      @(negedge clk);
      tests++;
      if ({rsp_valid, ops_count} !== 17'h0) begin
        $display("FAIL abandoned_rsp: got v=%b ops=%0d required v=0 ops=0", rsp_valid, ops_count);
        fails++;
      end
    end
  endtask

  task automatic test_saturation;
    int unsigned accepts = 0, resps = 0, cyc = 0, last = 0;
    s_cmd_mode = MODE_INT; s_cmd_op = 2'd2; s_cmd_a = 16'($urandom); s_cmd_b = 16'($urandom);
    s_cmd_valid = 1'b1; s_rsp_ready = 1'b1;
    while (resps < 260 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (s_rsp_valid === 1'b1) begin
        tests++;
        if ({s_rsp_err, s_rsp_res, s_ops_count, s_err_count} !==
            {1'b1, s_cmd_a, s_cmd_b, 16'(resps), 8'((resps > 255) ? 255 : resps)}) begin
          $display("FAIL sat_rsp: got err=%b res=%h ops=%0d errs=%0d required err=1 res=%h%h ops=%0d errs=%0d",
                   s_rsp_err, s_rsp_res, s_ops_count, s_err_count, s_cmd_a, s_cmd_b,
                   resps, (resps > 255) ? 255 : resps);
          fails++;
        end
        resps++;
      end
      if (s_cmd_valid && s_cmd_ready === 1'b1) begin
        if (accepts > 0) begin
          tests++;
          if (cyc - last != 3) begin
            $display("FAIL sat_period: got %0d cycles required 3", cyc - last);
            fails++;
          end
        end
        last = cyc;
        accepts++;
        if (accepts == 260) s_cmd_valid = 1'b0;
      end
    end
    @(negedge clk);
    s_rsp_ready = 1'b0;
    tests++;
    if ({s_ops_count, s_err_count} !== {16'd260, 8'd255}) begin
      $display("FAIL sat_final: got ops=%0d errs=%0d required ops=260 errs=255", s_ops_count, s_err_count);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_not();
    test_backpressure();
    test_err_mask();
    test_random();
    test_reset_mid_op();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
